apb_mem_slave_param: RTL and testbench

- Parametrised APB4 completer fronting a synchronous single-port memory with 1-cycle read latency.
- Generalises the fixed-width APB memory slave with: configurable data/address width and memory depth, programmable wait states, alignment checking, and registered memory strobes.
- Sits behind the APB bridge and decoder, one instance per memory region.

---
 rtl/apb_slv_pkg.sv | 30 +++
 rtl/apb_wait_cnt.sv | 42 ++++
 rtl/apb_mem_slave_param.sv | 165 ++++++++++++++++
 tb/tb_apb_mem_slave_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the parametrised APB memory completer.
//   apb_state_e : completer FSM states (IDLE, ACCESS)
//   WAIT_W      : width of the wait-state counter (WAIT_STATES 0..15)
//   apb_req_t   : captured request, sized for the widest supported bus
//   word_shift  : byte-address to word-index shift for a given data width
package apb_slv_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   localparam int unsigned WAIT_W     = 4;
   localparam int unsigned REQ_ADDR_W = 64;
   localparam int unsigned REQ_DATA_W = 64;
   localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

   // Fields are zero-extended from the configured bus widths on capture.
   typedef struct packed {
      logic                  write;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [REQ_STRB_W-1:0] strb;
   } apb_req_t;

   function automatic int unsigned word_shift(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Loadable down-counter used to time pready in the ACCESS phase.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one, saturating at zero
//   value_o      : current count
//   zero_o       : count equals zero
module apb_wait_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] value_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;
   assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/apb_mem_slave_param.sv
// APB4 completer in front of a synchronous single-port memory (1-cycle read
// latency). Captures the request in the setup cycle, pulses one registered
// memory strobe in the first ACCESS cycle and completes after a programmable
// number of wait states. Flags out-of-range and (optionally) misaligned
// addresses with pslverr.
//
// Optional feature macro: APB_SLV_PROT_EN -- when defined, writes with
// pprot[0]=0 (unprivileged) are blocked and answered with pslverr.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   psel, penable  : APB select / access phase
//   pwrite, paddr  : direction, byte address
//   pwdata, pstrb  : write data, byte strobes
//   pprot          : protection attributes (APB_SLV_PROT_EN only)
//   prdata, pready, pslverr : APB response
//   mem_wr, mem_rd : one-cycle memory write / read strobes
//   mem_be         : byte enables (all ones for reads)
//   mem_address    : memory word address
//   mem_data_in    : memory write data
//   mem_data_out   : memory read data, valid the cycle after mem_rd
module apb_mem_slave_param
   import apb_slv_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ALIGN_CHK   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   input  logic [2:0]                   pprot,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic                         mem_wr,
   output logic                         mem_rd,
   output logic [DATA_W/8-1:0]          mem_be,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_address,
   output logic [DATA_W-1:0]            mem_data_in,
   input  logic [DATA_W-1:0]            mem_data_out
);

   localparam int unsigned SHIFT  = word_shift(DATA_W);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);

   localparam logic [REQ_ADDR_W-1:0] LOW_MASK = (64'd1 << SHIFT) - 64'd1;
   localparam logic [WAIT_W-1:0]     WR_WAIT  = WAIT_W'(WAIT_STATES);
   localparam logic [WAIT_W-1:0]     RD_WAIT  = WAIT_W'((WAIT_STATES == 0) ? 1 : WAIT_STATES);

   apb_state_e  state_q, state_d;
   apb_req_t    req_q, req_d;
   logic        err_q, err_d;
   logic        mem_wr_q, mem_wr_d;
   logic        mem_rd_q, mem_rd_d;

   logic              setup;
   logic              range_err, align_err, prot_err;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [WAIT_W-1:0] cnt_load_val, cnt_val;

   assign setup = (state_q == IDLE) && psel && !penable;

   always_comb begin
      req_d = '{write: pwrite,
                addr:  REQ_ADDR_W'(paddr),
                wdata: REQ_DATA_W'(pwdata),
                strb:  REQ_STRB_W'(pstrb)};
   end

   assign range_err = (req_d.addr >> SHIFT) >= REQ_ADDR_W'(MEM_DEPTH);
   assign align_err = (ALIGN_CHK != 0) && ((req_d.addr & LOW_MASK) != '0);

`ifdef APB_SLV_PROT_EN
   logic prot_unused;
   assign prot_unused = ^pprot[2:1];
   assign prot_err    = pwrite && !pprot[0];
`else
   logic prot_unused;
   assign prot_unused = ^pprot;
   assign prot_err    = 1'b0;
`endif

   assign err_d = range_err || align_err || prot_err;

   // Reads need at least one wait so mem_data_out is valid at pready.
   assign cnt_load_val = (!pwrite && !err_d) ? RD_WAIT : WR_WAIT;

   always_comb begin
      state_d  = state_q;
      mem_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (setup) begin
               state_d  = ACCESS;
               cnt_load = 1'b1;
               mem_wr_d = pwrite && !err_d && (pstrb != '0);
               mem_rd_d = !pwrite && !err_d;
            end
         end
         ACCESS: begin
            if (cnt_zero || !psel) begin
               state_d = IDLE;
            end else begin
               cnt_dec = (cnt_val != '0);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         err_q    <= 1'b0;
         mem_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_wr_q <= mem_wr_d;
         mem_rd_q <= mem_rd_d;
         if (setup) begin
            req_q <= req_d;
            err_q <= err_d;
         end
      end
   end

   apb_wait_cnt #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .value_o    (cnt_val),
      .zero_o     (cnt_zero)
   );

   assign pready  = (state_q == ACCESS) && cnt_zero;
   assign pslverr = pready && err_q;
   assign prdata  = (pready && !req_q.write && !err_q) ? mem_data_out : '0;

   // Address/data/enables come from the capture register but are only
   // presented while one of the registered strobes is high.
   assign mem_wr      = mem_wr_q;
   assign mem_rd      = mem_rd_q;
   assign mem_address = (mem_wr_q || mem_rd_q) ? MEM_AW'(req_q.addr >> SHIFT) : '0;
   assign mem_data_in = (mem_wr_q || mem_rd_q) ? DATA_W'(req_q.wdata) : '0;
   assign mem_be      = mem_wr_q ? STRB_W'(req_q.strb) :
                        mem_rd_q ? {STRB_W{1'b1}} : '0;

endmodule

// File: tb/tb_apb_mem_slave_param.sv
module tb_apb_mem_slave_param;

   typedef struct {
      int          inst;
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } rsp_t;

   typedef struct {
      int          inst;
      logic        wr;
      logic        rd;
      logic [7:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } stb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  psel_v;
   logic        penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   logic        pready_w  [3];
   logic        pslverr_w [3];
   logic        mem_wr_w  [3];
   logic        mem_rd_w  [3];
   logic [31:0] prdata_w  [3];
   logic [31:0] mem_din_w [3];
   logic [31:0] mdo       [3];
   logic [3:0]  mem_be_w  [3];
   logic [7:0]  mem_addr_w[3];

   logic [31:0] mem_m [0:767];

   rsp_t rsp_q[$];
   stb_t stb_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc [3];
   bit setup_seen [3];

   always #5 clk = ~clk;

   // Instance 0: WAIT_STATES=2, ALIGN_CHK=1; 1: WAIT_STATES=2, ALIGN_CHK=0; 2: WAIT_STATES=0.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_mem_slave_param #(
         .ADDR_W      (12),
         .DATA_W      (32),
         .MEM_DEPTH   (256),
         .WAIT_STATES ((g == 2) ? 0 : 2),
         .ALIGN_CHK   ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .psel         (psel_v[g]),
         .penable      (penable),
         .pwrite       (pwrite),
         .paddr        (paddr),
         .pwdata       (pwdata),
         .pstrb        (pstrb),
         .pprot        (pprot),
         .prdata       (prdata_w[g]),
         .pready       (pready_w[g]),
         .pslverr      (pslverr_w[g]),
         .mem_wr       (mem_wr_w[g]),
         .mem_rd       (mem_rd_w[g]),
         .mem_be       (mem_be_w[g]),
         .mem_address  (mem_addr_w[g]),
         .mem_data_in  (mem_din_w[g]),
         .mem_data_out (mdo[g])
      );
   end

   // Memory behind each instance: 1-cycle read latency, data held afterwards.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (mem_wr_w[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be_w[i][b]) mem_m[i*256 + int'(mem_addr_w[i])][b*8 +: 8] <= mem_din_w[i][b*8 +: 8];
            end
         end
         if (mem_rd_w[i]) mdo[i] <= mem_m[i*256 + int'(mem_addr_w[i])];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) setup_seen[i] = psel_v[i] && !penable && !rst;
   end

   // Monitor: counts ACCESS cycles and checks every response/strobe against the queues.
   always @(negedge clk) begin
      rsp_t r;
      stb_t s;
      for (int i = 0; i < 3; i++) begin
         if (setup_seen[i]) acc[i] = 1;
         else acc[i] = acc[i] + 1;

         if (pready_w[i]) begin
            checks++;
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pready inst %0d: pready=1 with no transfer outstanding", i);
            end else begin
               r = rsp_q.pop_front();
               if (r.inst != i || r.rdata !== prdata_w[i] || r.err !== pslverr_w[i] || r.acc != acc[i]) begin
                  errors++;
                  $display("FAIL response inst %0d: got prdata=%h pslverr=%b access_cycle=%0d, expected inst %0d prdata=%h pslverr=%b access_cycle=%0d",
                           i, prdata_w[i], pslverr_w[i], acc[i], r.inst, r.rdata, r.err, r.acc);
               end
            end
         end else if (pslverr_w[i] || prdata_w[i] != '0) begin
            checks++;
            errors++;
            $display("FAIL idle_response inst %0d: got pslverr=%b prdata=%h, expected 0/0 without pready", i, pslverr_w[i], prdata_w[i]);
         end

         if (mem_wr_w[i] || mem_rd_w[i]) begin
            checks++;
            if (stb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe inst %0d: mem_wr=%b mem_rd=%b addr=%0d", i, mem_wr_w[i], mem_rd_w[i], mem_addr_w[i]);
            end else begin
               s = stb_q.pop_front();
               if (s.inst != i || s.wr !== mem_wr_w[i] || s.rd !== mem_rd_w[i] || s.addr !== mem_addr_w[i] ||
                   s.be !== mem_be_w[i] || s.data !== mem_din_w[i] || acc[i] != 1) begin
                  errors++;
                  $display("FAIL strobe inst %0d: got wr=%b rd=%b addr=%0d be=%h data=%h cycle=%0d, expected inst %0d wr=%b rd=%b addr=%0d be=%h data=%h cycle=1",
                           i, mem_wr_w[i], mem_rd_w[i], mem_addr_w[i], mem_be_w[i], mem_din_w[i], acc[i],
                           s.inst, s.wr, s.rd, s.addr, s.be, s.data);
               end
            end
         end else if (mem_be_w[i] != '0 || mem_addr_w[i] != '0 || mem_din_w[i] != '0) begin
            checks++;
            errors++;
            $display("FAIL idle_mem inst %0d: got be=%h addr=%0d data=%h, expected all 0 without a strobe",
                     i, mem_be_w[i], mem_addr_w[i], mem_din_w[i]);
         end
      end
   end

   task automatic exp_rsp(input int i, input logic [31:0] d, input logic e, input int a);
      rsp_t r;
      r = '{i, d, e, a};
      rsp_q.push_back(r);
   endtask

   task automatic exp_stb(input int i, input logic w, input logic r, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] d);
      stb_t s;
      s = '{i, w, r, a, be, d};
      stb_q.push_back(s);
   endtask

   task automatic xfer(input int i, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      int n;
      psel_v    = '0;
      psel_v[i] = 1'b1;
      penable   = 1'b0;
      pwrite    = wr;
      paddr     = a;
      pwdata    = d;
      pstrb     = s;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      while (!pready_w[i] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!pready_w[i]) begin
         checks++;
         errors++;
         $display("FAIL timeout inst %0d addr %h: pready=0 after 40 cycles, expected completion", i, a);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      psel_v  = '0;
      penable = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_quiet(input string name, input int i);
      logic [82:0] v;
      v = {pready_w[i], pslverr_w[i], prdata_w[i], mem_wr_w[i], mem_rd_w[i],
           mem_be_w[i], mem_addr_w[i], mem_din_w[i]};
      checks++;
      if (v != '0) begin
         errors++;
         $display("FAIL %s inst %0d: outputs=%h, expected all 0", name, i, v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1; psel_v = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check_quiet("reset_state", i);
      rst = 1'b0;
      idle(2);

      // Write / read of word 4 with two wait states.
      exp_stb(0, 1, 0, 8'd4, 4'hF, 32'hDEADBEEF);
      exp_rsp(0, 32'h0, 0, 3);
      xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
      exp_stb(0, 0, 1, 8'd4, 4'hF, 32'h0);
      exp_rsp(0, 32'hDEADBEEF, 0, 3);
      xfer(0, 0, 12'h010, 32'h0, 4'h0);
      idle(1);

      // Out of range and misaligned: error, no strobes.
      exp_rsp(0, 32'h0, 1, 3);
      xfer(0, 1, 12'h400, 32'h55555555, 4'hF);
      exp_rsp(0, 32'h0, 1, 3);
      xfer(0, 0, 12'h011, 32'h0, 4'h0);
      idle(1);

      // Partial write merges bytes 1 and 2.
      exp_stb(0, 1, 0, 8'd4, 4'h6, 32'hAABBCCDD);
      exp_rsp(0, 32'h0, 0, 3);
      xfer(0, 1, 12'h010, 32'hAABBCCDD, 4'h6);
      exp_stb(0, 0, 1, 8'd4, 4'hF, 32'h0);
      exp_rsp(0, 32'hDEBBCCEF, 0, 3);
      xfer(0, 0, 12'h010, 32'h0, 4'h0);

      // Zero strobes: legal no-op, no mem_wr.
      exp_rsp(0, 32'h0, 0, 3);
      xfer(0, 1, 12'h020, 32'h99999999, 4'h0);
      idle(1);

      // Alignment checking disabled: 0x011 lands on word 4.
      exp_stb(1, 1, 0, 8'd4, 4'hF, 32'h12345678);
      exp_rsp(1, 32'h0, 0, 3);
      xfer(1, 1, 12'h011, 32'h12345678, 4'hF);
      exp_stb(1, 0, 1, 8'd4, 4'hF, 32'h0);
      exp_rsp(1, 32'h12345678, 0, 3);
      xfer(1, 0, 12'h012, 32'h0, 4'h0);
      idle(1);

      // No wait states, back-to-back write then read: 5 cycles in total.
      exp_stb(2, 1, 0, 8'd1, 4'hF, 32'hCAFEF00D);
      exp_rsp(2, 32'h0, 0, 1);
      exp_stb(2, 0, 1, 8'd1, 4'hF, 32'h0);
      exp_rsp(2, 32'hCAFEF00D, 0, 2);
      c0 = cyc;
      xfer(2, 1, 12'h004, 32'hCAFEF00D, 4'hF);
      xfer(2, 0, 12'h004, 32'h0, 4'h0);
      checks++;
      if (cyc - c0 != 5) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d cycles, expected 5", cyc - c0);
      end
      exp_rsp(2, 32'h0, 1, 1);
      xfer(2, 0, 12'h400, 32'h0, 4'h0);
      idle(1);

      // Access phase without a setup cycle is ignored.
      psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_quiet("no_setup_ignored", 0);
      idle(1);

      // Abort after the first ACCESS cycle: strobe already issued, no pready.
      exp_stb(0, 0, 1, 8'd4, 4'hF, 32'h0);
      psel_v = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'h0;
      @(posedge clk); #1;
      idle(5);
      exp_stb(0, 0, 1, 8'd4, 4'hF, 32'h0);
      exp_rsp(0, 32'hDEBBCCEF, 0, 3);
      xfer(0, 0, 12'h010, 32'h0, 4'h0);
      idle(1);

      // Reset while in ACCESS with one wait cycle left.
      exp_stb(0, 1, 0, 8'd12, 4'hF, 32'h11223344);
      psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h11223344; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("reset_mid_access", 0);
      rst = 1'b0;
      idle(3);
      check_quiet("idle_after_reset", 0);
      exp_stb(0, 0, 1, 8'd12, 4'hF, 32'h0);
      exp_rsp(0, 32'h11223344, 0, 3);
      xfer(0, 0, 12'h030, 32'h0, 4'h0);
      idle(1);

`ifdef APB_SLV_PROT_EN
      // Unprivileged write is blocked; unprivileged read still works.
      pprot = 3'b000;
      exp_rsp(0, 32'h0, 1, 3);
      xfer(0, 1, 12'h040, 32'h77777777, 4'hF);
      exp_stb(0, 0, 1, 8'd4, 4'hF, 32'h0);
      exp_rsp(0, 32'hDEBBCCEF, 0, 3);
      xfer(0, 0, 12'h010, 32'h0, 4'h0);
      pprot = 3'b001;
      idle(1);
`endif

      idle(4);
      checks++;
      if (rsp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_responses: %0d left, expected 0", rsp_q.size());
      end
      checks++;
      if (stb_q.size() != 0) begin
         errors++;
         $display("FAIL pending_strobes: %0d left, expected 0", stb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
